// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register-number width, the zero register
// and the stall FSM state encoding used by the hazard logic.
package pipeline_pkg;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = '0;

   typedef enum logic [1:0] {
      HZ_IDLE   = 2'd0,
      HZ_HOLD   = 2'd1,
      HZ_FREEZE = 2'd2
   } hz_state_t;

endpackage

// File: rtl/hazard_match.sv
// Combinational source/destination comparator: does the instruction in ID
// read the register that an older instruction is about to write?
module hazard_match #(
   parameter int W = pipeline_pkg::REG_W
) (
   input  logic [W-1:0] rs,
   input  logic [W-1:0] rt,
   input  logic         uses_rs,
   input  logic         uses_rt,
   input  logic [W-1:0] rd,
   output logic         match
);
   import pipeline_pkg::*;

   // $zero is never a real producer, so a match against it is void
   assign match = (rd != W'(REG_ZERO)) &&
                  ((uses_rs && (rs == rd)) || (uses_rt && (rt == rd)));

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller covering the hazards operand forwarding cannot.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_stall_unit #(
   parameter int REG_W = pipeline_pkg::REG_W
`ifdef HAZARD_STATS_EN
   , parameter int STAT_W = 32
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] ID_rs,
   input  logic [REG_W-1:0] ID_rt,
   input  logic             ID_usesRs,
   input  logic             ID_usesRt,
   input  logic             ID_isBranch,
   input  logic             ID_EX_regWrite,
   input  logic             ID_EX_memRead,
   input  logic [REG_W-1:0] ID_EX_rd,
   input  logic             EX_MEM_memRead,
   input  logic [REG_W-1:0] EX_MEM_rd,
   input  logic             branchTaken,
   input  logic             memBusy,
   output logic             pcWrite,
   output logic             IF_ID_write,
   output logic             IF_ID_flush,
   output logic             ID_EX_bubble,
   output logic [1:0]       stallState
`ifdef HAZARD_STATS_EN
   , output logic [STAT_W-1:0] stallCycles
   , output logic [STAT_W-1:0] flushCount
   , output logic [STAT_W-1:0] freezeCycles
`endif
);
   import pipeline_pkg::*;

   hz_state_t        state_reg, state_next;
   logic [REG_W-1:0] rd_sel [2];
   logic [1:0]       match;
   logic             load_use, br_alu, br_load_ex, br_load_mem, stall_req;

   // index 0 compares against EX, index 1 against MEM
   assign rd_sel[0] = ID_EX_rd;
   assign rd_sel[1] = EX_MEM_rd;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_match
         hazard_match #(.W(REG_W)) u_match (
            .rs      (ID_rs),
            .rt      (ID_rt),
            .uses_rs (ID_usesRs),
            .uses_rt (ID_usesRt),
            .rd      (rd_sel[gi]),
            .match   (match[gi])
         );
      end
   endgenerate

   assign load_use    = ID_EX_memRead && match[0];
   assign br_alu      = ID_isBranch && ID_EX_regWrite && !ID_EX_memRead && match[0];
   assign br_load_ex  = ID_isBranch && ID_EX_memRead && match[0];
   assign br_load_mem = ID_isBranch && EX_MEM_memRead && match[1];
   assign stall_req   = load_use || br_alu || br_load_ex || br_load_mem;

   always_comb begin
      state_next   = state_reg;
      pcWrite      = 1'b1;
      IF_ID_write  = 1'b1;
      IF_ID_flush  = 1'b0;
      ID_EX_bubble = 1'b0;
      case (state_reg)
         HZ_IDLE: begin
            if (memBusy) begin
               pcWrite     = 1'b0;
               IF_ID_write = 1'b0;
               state_next  = HZ_FREEZE;
            end else if (stall_req) begin
               pcWrite      = 1'b0;
               IF_ID_write  = 1'b0;
               ID_EX_bubble = 1'b1;
               state_next   = br_load_ex ? HZ_HOLD : HZ_IDLE;
            end else if (ID_isBranch && branchTaken) begin
               IF_ID_flush = 1'b1;
            end
         end
         HZ_HOLD: begin
            pcWrite     = 1'b0;
            IF_ID_write = 1'b0;
            // a freeze here drops the pending bubble; brLoadMem re-raises it later
            if (memBusy) begin
               state_next = HZ_FREEZE;
            end else begin
               ID_EX_bubble = 1'b1;
               state_next   = HZ_IDLE;
            end
         end
         HZ_FREEZE: begin
            pcWrite     = 1'b0;
            IF_ID_write = 1'b0;
            if (!memBusy) state_next = HZ_IDLE;
         end
         default: state_next = HZ_IDLE;
      endcase
      stallState = state_reg;
      if (reset) begin
         state_next   = HZ_IDLE;
         pcWrite      = 1'b1;
         IF_ID_write  = 1'b1;
         IF_ID_flush  = 1'b0;
         ID_EX_bubble = 1'b0;
         stallState   = 2'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_reg <= HZ_IDLE;
      else       state_reg <= state_next;
   end

`ifdef HAZARD_STATS_EN
   logic [2:0] stat_inc;

   assign stat_inc = {!pcWrite && !ID_EX_bubble, IF_ID_flush, ID_EX_bubble};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_stat
         logic [STAT_W-1:0] cnt_reg;
         always_ff @(posedge clk) begin
            if (reset)
               cnt_reg <= '0;
            else if (stat_inc[gi] && (cnt_reg != {STAT_W{1'b1}}))
               cnt_reg <= cnt_reg + STAT_W'(1);
         end
      end
   endgenerate

   assign stallCycles  = g_stat[0].cnt_reg;
   assign flushCount   = g_stat[1].cnt_reg;
   assign freezeCycles = g_stat[2].cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit; expected output vectors are queued
// when each cycle's inputs are driven and compared mid-cycle.
module tb_hazard_stall_unit;

   localparam logic [5:0] RUN   = 6'b110000;
   localparam logic [5:0] FLUSH = 6'b111000;
   localparam logic [5:0] ST0   = 6'b000100;
   localparam logic [5:0] ST1   = 6'b000101;
   localparam logic [5:0] FZ0   = 6'b000000;
   localparam logic [5:0] FZ1   = 6'b000001;
   localparam logic [5:0] FZ2   = 6'b000010;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] ID_rs, ID_rt, ID_EX_rd, EX_MEM_rd;
   logic       ID_usesRs, ID_usesRt, ID_isBranch, ID_EX_regWrite, ID_EX_memRead;
   logic       EX_MEM_memRead, branchTaken, memBusy;
   logic       pcWrite, IF_ID_write, IF_ID_flush, ID_EX_bubble;
   logic [1:0] stallState;
`ifdef HAZARD_STATS_EN
   logic [31:0] stallCycles, flushCount, freezeCycles;
   int unsigned e_stall = 0, e_flush = 0, e_frz = 0;
   bit          stats_known = 1'b0;
`endif

   int err_cnt = 0;
   int chk_cnt = 0;

   logic [5:0] exp_q [$];
   string      tag_q [$];

   always #5 clk = ~clk;

   hazard_stall_unit dut (
      .clk            (clk),
      .reset          (reset),
      .ID_rs          (ID_rs),
      .ID_rt          (ID_rt),
      .ID_usesRs      (ID_usesRs),
      .ID_usesRt      (ID_usesRt),
      .ID_isBranch    (ID_isBranch),
      .ID_EX_regWrite (ID_EX_regWrite),
      .ID_EX_memRead  (ID_EX_memRead),
      .ID_EX_rd       (ID_EX_rd),
      .EX_MEM_memRead (EX_MEM_memRead),
      .EX_MEM_rd      (EX_MEM_rd),
      .branchTaken    (branchTaken),
      .memBusy        (memBusy),
      .pcWrite        (pcWrite),
      .IF_ID_write    (IF_ID_write),
      .IF_ID_flush    (IF_ID_flush),
      .ID_EX_bubble   (ID_EX_bubble),
      .stallState     (stallState)
`ifdef HAZARD_STATS_EN
      , .stallCycles  (stallCycles)
      , .flushCount   (flushCount)
      , .freezeCycles (freezeCycles)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: got %0h", tag, got);
      end
   endtask

   task automatic clr();
      reset = 0; ID_rs = 0; ID_rt = 0; ID_usesRs = 0; ID_usesRt = 0;
      ID_isBranch = 0; ID_EX_regWrite = 0; ID_EX_memRead = 0; ID_EX_rd = 0;
      EX_MEM_memRead = 0; EX_MEM_rd = 0; branchTaken = 0; memBusy = 0;
   endtask

   // inputs already driven; queue expectation, compare mid-cycle, advance
   task automatic step(input string tag, input logic [5:0] exp);
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(negedge clk);
      chk(tag_q.pop_front(),
          {26'd0, pcWrite, IF_ID_write, IF_ID_flush, ID_EX_bubble, stallState},
          {26'd0, exp_q.pop_front()});
`ifdef HAZARD_STATS_EN
      if (stats_known) begin
         chk({tag, "_nstall"},  stallCycles,  e_stall);
         chk({tag, "_nflush"},  flushCount,   e_flush);
         chk({tag, "_nfreeze"}, freezeCycles, e_frz);
      end
      if (reset) begin
         e_stall = 0; e_flush = 0; e_frz = 0; stats_known = 1'b1;
      end else begin
         e_stall += int'(exp[2]);
         e_flush += int'(exp[3]);
         e_frz   += int'(!exp[5] && !exp[2]);
      end
`endif
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr();
      @(posedge clk);
      #1;

      // reset forces run outputs regardless of hazards
      clr(); reset = 1; ID_rs = 2; ID_usesRs = 1; ID_EX_memRead = 1; ID_EX_rd = 2;
      step("rst_lduse", RUN);
      clr(); reset = 1; memBusy = 1; step("rst_busy", RUN);
      clr(); reset = 1; step("rst_idle", RUN);

      // load-use
      clr(); ID_rs = 2; ID_usesRs = 1; ID_EX_memRead = 1; ID_EX_regWrite = 1; ID_EX_rd = 2;
      step("lduse", ST0);
      clr(); step("lduse_go", RUN);
      clr(); ID_rt = 7; ID_EX_memRead = 1; ID_EX_rd = 7; step("rt_unused", RUN);
      clr(); ID_rt = 7; ID_usesRt = 1; ID_EX_memRead = 1; ID_EX_rd = 7; step("rt_lduse", ST0);

      // register zero never matches
      clr(); ID_usesRs = 1; ID_EX_memRead = 1; step("zero_ex", RUN);
      clr(); ID_isBranch = 1; ID_usesRt = 1; EX_MEM_memRead = 1; step("zero_mem", RUN);

      // branch on a load in EX: two stall cycles
      clr(); ID_isBranch = 1; ID_rs = 3; ID_usesRs = 1; ID_EX_memRead = 1; ID_EX_regWrite = 1; ID_EX_rd = 3;
      step("brldex1", ST0);
      clr(); ID_isBranch = 1; ID_rs = 3; ID_usesRs = 1; EX_MEM_memRead = 1; EX_MEM_rd = 3;
      step("brldex2", ST1);
      clr(); ID_isBranch = 1; ID_rs = 3; ID_usesRs = 1; step("brldex_go", RUN);

      // HOLD is forced and ignores branchTaken
      clr(); ID_isBranch = 1; ID_rt = 9; ID_usesRt = 1; ID_EX_memRead = 1; ID_EX_rd = 9; branchTaken = 1;
      step("brldex_rt", ST0);
      clr(); ID_isBranch = 1; ID_rt = 9; ID_usesRt = 1; branchTaken = 1; step("hold_forced", ST1);
      step("hold_exit_flush", FLUSH);

      // taken-branch flush
      clr(); ID_isBranch = 1; ID_rs = 5; ID_usesRs = 1; branchTaken = 1; step("flush", FLUSH);
      clr(); step("flush_once", RUN);

      // ALU dependence on branch stalls first, flush afterwards
      clr(); ID_isBranch = 1; branchTaken = 1; ID_rs = 4; ID_usesRs = 1; ID_EX_regWrite = 1; ID_EX_rd = 4;
      step("bralu", ST0);
      clr(); ID_isBranch = 1; branchTaken = 1; ID_rs = 4; ID_usesRs = 1; step("bralu_flush", FLUSH);
      clr(); ID_rs = 4; ID_usesRs = 1; ID_EX_regWrite = 1; ID_EX_rd = 4; step("alu_fwd", RUN);
      clr(); ID_rs = 6; ID_usesRs = 1; EX_MEM_memRead = 1; EX_MEM_rd = 6; step("mem_fwd", RUN);

      // branch on a load in MEM
      clr(); ID_isBranch = 1; ID_rs = 6; ID_usesRs = 1; EX_MEM_memRead = 1; EX_MEM_rd = 6;
      step("brldmem", ST0);
      clr(); ID_isBranch = 1; ID_rs = 6; ID_usesRs = 1; step("brldmem_go", RUN);
      clr(); ID_isBranch = 1; ID_rs = 6; ID_usesRs = 1; EX_MEM_rd = 6; step("br_alu_mem", RUN);

      // memory busy for three cycles while in HOLD
      clr(); ID_isBranch = 1; ID_rs = 3; ID_usesRs = 1; ID_EX_memRead = 1; ID_EX_rd = 3;
      step("mb_ldex", ST0);
      clr(); ID_isBranch = 1; ID_rs = 3; ID_usesRs = 1; EX_MEM_memRead = 1; EX_MEM_rd = 3; memBusy = 1;
      step("mb_hold", FZ1);
      step("mb_frz1", FZ2);
      step("mb_frz2", FZ2);
      memBusy = 0; step("mb_frz_exit", FZ2);
      step("mb_brldmem", ST0);
      clr(); ID_isBranch = 1; ID_rs = 3; ID_usesRs = 1; step("mb_done", RUN);

      // memBusy outranks stall requests and flushes
      clr(); ID_rs = 2; ID_usesRs = 1; ID_EX_memRead = 1; ID_EX_rd = 2; memBusy = 1;
      step("busy_lduse", FZ0);
      memBusy = 0; step("busy_exit", FZ2);
      step("busy_then_lduse", ST0);
      clr(); ID_isBranch = 1; branchTaken = 1; memBusy = 1; step("busy_flush", FZ0);
      clr(); step("busy_flush_exit", FZ2);
      step("idle", RUN);

      // reset in HOLD and in FREEZE leaves no residual stall
      clr(); ID_isBranch = 1; ID_rs = 3; ID_usesRs = 1; ID_EX_memRead = 1; ID_EX_rd = 3;
      step("rh_ldex", ST0);
      reset = 1; step("rh_reset", RUN);
      clr(); step("rh_idle", RUN);
      clr(); memBusy = 1; step("rf_busy", FZ0);
      step("rf_frz", FZ2);
      reset = 1; step("rf_reset", RUN);
      clr(); step("rf_idle", RUN);
      step("rf_idle2", RUN);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
